// File: rtl/decode_stage_p.sv
// decode_stage_p: integer register file with write-to-read bypass, load-use hazard detection and ID/EX register.
// Latency: one cycle from decode inputs to the *_e outputs; register writes are visible on a0 after the edge.
// Backpressure: stall_ext holds ID/EX; stall_fd holds fetch and IF/ID on stall_ext or a load-use hazard.
module decode_stage_p #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int CTRL_W   = 16,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr_d,
    input  logic              valid_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pc_plus4_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              is_load_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic              we3,
    input  logic [4:0]        a3,
    input  logic [XLEN-1:0]   wd3,
    input  logic              stall_ext,
    input  logic              flush_e,
    output logic              stall_fd,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pc_plus4_e,
    output logic [4:0]        rs1_e,
    output logic [4:0]        rs2_e,
    output logic [4:0]        rd_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic              is_load_e,
    output logic              valid_e,
    output logic [XLEN-1:0]   a0
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef struct packed {
        logic              valid;
        logic              is_load;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
    } idex_t;

    function automatic logic legal(input logic [4:0] idx);
        return 32'(idx) < 32'(NUM_REGS);
    endfunction

    logic [XLEN-1:0] rf [NUM_REGS];
    logic [4:0]      rs1, rs2, rd;
    logic            wr_en;
    logic [XLEN-1:0] rd1, rd2;
    logic            lu;
    idex_t           q, d_next;
    logic            unused_instr;

    assign rs1 = instr_d[19:15];
    assign rs2 = instr_d[24:20];
    assign rd  = instr_d[11:7];
    assign unused_instr = ^{instr_d[31:25], instr_d[14:12], instr_d[6:0]};

    // x0 and out-of-range destinations are silently dropped.
    assign wr_en = we3 && (a3 != 5'd0) && legal(a3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[a3[AW-1:0]] <= wd3;
        end
    end

    always_comb begin
        rd1 = '0;
        if (rs1 != 5'd0 && legal(rs1)) begin
            if (BYPASS != 0 && wr_en && a3 == rs1) rd1 = wd3;
            else                                   rd1 = rf[rs1[AW-1:0]];
        end
    end

    always_comb begin
        rd2 = '0;
        if (rs2 != 5'd0 && legal(rs2)) begin
            if (BYPASS != 0 && wr_en && a3 == rs2) rd2 = wd3;
            else                                   rd2 = rf[rs2[AW-1:0]];
        end
    end

    assign lu = q.valid & q.is_load & (q.rd != 5'd0) & valid_d &
                ((q.rd == rs1) | (q.rd == rs2));
    assign stall_fd = lu | stall_ext;

    always_comb begin
        d_next          = '0;
        d_next.valid    = valid_d;
        d_next.is_load  = is_load_d;
        d_next.ctrl     = ctrl_d;
        d_next.rd1      = rd1;
        d_next.rd2      = rd2;
        d_next.imm      = imm_d;
        d_next.pc       = pc_d;
        d_next.pc_plus4 = pc_plus4_d;
        d_next.rs1      = rs1;
        d_next.rs2      = rs2;
        d_next.rd       = rd;
    end

    // Flush outranks stall; a load-use bubble only lands when EX is free to advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         q <= '0;
        else if (flush_e)   q <= '0;
        else if (stall_ext) q <= q;
        else if (lu)        q <= '0;
        else                q <= d_next;
    end

    assign valid_e    = q.valid;
    assign is_load_e  = q.is_load;
    assign ctrl_e     = q.ctrl;
    assign rd1_e      = q.rd1;
    assign rd2_e      = q.rd2;
    assign imm_e      = q.imm;
    assign pc_e       = q.pc;
    assign pc_plus4_e = q.pc_plus4;
    assign rs1_e      = q.rs1;
    assign rs2_e      = q.rs2;
    assign rd_e       = q.rd;

    generate
        if (NUM_REGS > 10) begin : g_a0
            assign a0 = rf[AW'(10)];
        end else begin : g_no_a0
            assign a0 = '0;
        end
    endgenerate

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: default build plus a BYPASS=0 / NUM_REGS=16 build sharing one input stream.
module tb_decode_stage_p;

    typedef struct packed {
        logic        valid;
        logic        is_load;
        logic [15:0] ctrl;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } ex_t;

    typedef struct {
        logic        vld, ld;
        logic [4:0]  rd, rs1, rs2;
        logic        we;
        logic [4:0]  a;
        logic [31:0] wd;
        logic        se, fl;
        logic [15:0] ctrl;
        logic        e_stall, e_valid;
        logic [31:0] e_rd1_0, e_rd1_1, e_a0;
    } vec_t;

    logic        clk, rst_n;
    logic [31:0] instr_d, pc_d, pc_plus4_d, imm_d, wd3;
    logic        valid_d, is_load_d, we3, stall_ext, flush_e;
    logic [15:0] ctrl_d;
    logic [4:0]  a3;

    logic        stall_fd0, stall_fd1, valid_e0, valid_e1, is_load_e0, is_load_e1;
    logic [31:0] rd1_e0, rd2_e0, imm_e0, pc_e0, pc4_e0, a0_0;
    logic [31:0] rd1_e1, rd2_e1, imm_e1, pc_e1, pc4_e1, a0_1;
    logic [4:0]  rs1_e0, rs2_e0, rd_e0, rs1_e1, rs2_e1, rd_e1;
    logic [15:0] ctrl_e0, ctrl_e1;
    ex_t         act0, act1;

    int          nvec = 0;
    int          nerr = 0;
    int          nregs [2] = '{32, 16};
    int          byp   [2] = '{1, 0};
    logic [31:0] m_rf [2][32];
    ex_t         m_ex [2];
    logic        last_stall;
    logic        m_stall;

    decode_stage_p dut0 (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .ctrl_d(ctrl_d), .is_load_d(is_load_d), .imm_d(imm_d),
        .we3(we3), .a3(a3), .wd3(wd3), .stall_ext(stall_ext), .flush_e(flush_e),
        .stall_fd(stall_fd0), .rd1_e(rd1_e0), .rd2_e(rd2_e0), .imm_e(imm_e0), .pc_e(pc_e0),
        .pc_plus4_e(pc4_e0), .rs1_e(rs1_e0), .rs2_e(rs2_e0), .rd_e(rd_e0), .ctrl_e(ctrl_e0),
        .is_load_e(is_load_e0), .valid_e(valid_e0), .a0(a0_0));

    decode_stage_p #(.NUM_REGS(16), .BYPASS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .ctrl_d(ctrl_d), .is_load_d(is_load_d), .imm_d(imm_d),
        .we3(we3), .a3(a3), .wd3(wd3), .stall_ext(stall_ext), .flush_e(flush_e),
        .stall_fd(stall_fd1), .rd1_e(rd1_e1), .rd2_e(rd2_e1), .imm_e(imm_e1), .pc_e(pc_e1),
        .pc_plus4_e(pc4_e1), .rs1_e(rs1_e1), .rs2_e(rs2_e1), .rd_e(rd_e1), .ctrl_e(ctrl_e1),
        .is_load_e(is_load_e1), .valid_e(valid_e1), .a0(a0_1));

    assign act0 = {valid_e0, is_load_e0, ctrl_e0, rd1_e0, rd2_e0, imm_e0, pc_e0, pc4_e0, rs1_e0, rs2_e0, rd_e0};
    assign act1 = {valid_e1, is_load_e1, ctrl_e1, rd1_e1, rd2_e1, imm_e1, pc_e1, pc4_e1, rs1_e1, rs2_e1, rd_e1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[dut%0d] at %0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] rd, rs1, rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
    endfunction

    // Architectural read as seen by a decode-stage instruction in the current cycle.
    function automatic logic [31:0] mread(input int d, input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= nregs[d]) return 32'h0;
        if (byp[d] != 0 && we3 && a3 == idx) return wd3;
        return m_rf[d][idx];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ex[d] = '0;
            for (int i = 0; i < 32; i++) m_rf[d][i] = 32'h0;
        end
    endtask

    task automatic check_all();
        ex_t a;
        for (int d = 0; d < 2; d++) begin
            a = (d == 0) ? act0 : act1;
            chk(d, "valid_e",    32'(a.valid),   32'(m_ex[d].valid));
            chk(d, "is_load_e",  32'(a.is_load), 32'(m_ex[d].is_load));
            chk(d, "ctrl_e",     32'(a.ctrl),    32'(m_ex[d].ctrl));
            chk(d, "rd1_e",      a.rd1,          m_ex[d].rd1);
            chk(d, "rd2_e",      a.rd2,          m_ex[d].rd2);
            chk(d, "imm_e",      a.imm,          m_ex[d].imm);
            chk(d, "pc_e",       a.pc,           m_ex[d].pc);
            chk(d, "pc_plus4_e", a.pc4,          m_ex[d].pc4);
            chk(d, "rs1_e",      32'(a.rs1),     32'(m_ex[d].rs1));
            chk(d, "rs2_e",      32'(a.rs2),     32'(m_ex[d].rs2));
            chk(d, "rd_e",       32'(a.rd),      32'(m_ex[d].rd));
            chk(d, "a0",         (d == 0) ? a0_0 : a0_1, m_rf[d][10]);
        end
    endtask

    // One clock: check the combinational stall, advance the model by the pipeline rules, compare.
    task automatic step();
        logic [4:0] s1, s2;
        logic       lu;
        ex_t        nxt [2];
        @(negedge clk);
        s1 = instr_d[19:15];
        s2 = instr_d[24:20];
        lu = m_ex[0].valid && m_ex[0].is_load && m_ex[0].rd != 5'd0 && valid_d &&
             (m_ex[0].rd == s1 || m_ex[0].rd == s2);
        m_stall    = lu | stall_ext;
        last_stall = stall_fd0;
        chk(0, "stall_fd", 32'(stall_fd0), 32'(m_stall));
        chk(1, "stall_fd", 32'(stall_fd1), 32'(m_stall));
        for (int d = 0; d < 2; d++) begin
            if (flush_e || (!stall_ext && lu)) nxt[d] = '0;
            else if (stall_ext)                nxt[d] = m_ex[d];
            else nxt[d] = '{valid: valid_d, is_load: is_load_d, ctrl: ctrl_d,
                            rd1: mread(d, s1), rd2: mread(d, s2), imm: imm_d, pc: pc_d,
                            pc4: pc_plus4_d, rs1: s1, rs2: s2, rd: instr_d[11:7]};
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            m_ex[d] = nxt[d];
            if (we3 && a3 != 5'd0 && int'(a3) < nregs[d]) m_rf[d][a3] = wd3;
        end
        check_all();
    endtask

    task automatic drive(input logic vld, ld, input logic [4:0] rd, rs1, rs2,
                         input logic we, input logic [4:0] a, input logic [31:0] wd,
                         input logic se, fl, input logic [15:0] ctrl);
        valid_d    = vld;
        is_load_d  = ld;
        instr_d    = mk_instr(rd, rs1, rs2);
        we3        = we;
        a3         = a;
        wd3        = wd;
        stall_ext  = se;
        flush_e    = fl;
        ctrl_d     = ctrl;
        pc_d       = 32'h1000 + 32'(ctrl) * 4;
        pc_plus4_d = pc_d + 32'd4;
        imm_d      = {16'h0, ctrl} ^ 32'h00A5_0000;
    endtask

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 5'd6, 5'd5,  5'd5, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 16'h11, 1'b0, 1'b1, 32'h0,    32'h0,  32'h0};
        tbl[1]  = '{1'b1, 1'b0, 5'd1, 5'd10, 5'd0, 1'b1, 5'd10, 32'h0000_00AB, 1'b0, 1'b0, 16'h12, 1'b0, 1'b1, 32'hAB,   32'h0,  32'hAB};
        tbl[2]  = '{1'b1, 1'b1, 5'd7, 5'd0,  5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 16'h13, 1'b0, 1'b1, 32'h0,    32'h0,  32'hAB};
        tbl[3]  = '{1'b1, 1'b0, 5'd8, 5'd7,  5'd2, 1'b1, 5'd7,  32'h55,       1'b0, 1'b0, 16'h14, 1'b1, 1'b0, 32'h0,    32'h0,  32'hAB};
        tbl[4]  = '{1'b1, 1'b0, 5'd8, 5'd7,  5'd2, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 16'h14, 1'b0, 1'b1, 32'h55,   32'h55, 32'hAB};
        tbl[5]  = '{1'b1, 1'b0, 5'd9, 5'd0,  5'd0, 1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 16'h15, 1'b0, 1'b1, 32'h0,    32'h0,  32'hAB};
        tbl[6]  = '{1'b1, 1'b0, 5'd3, 5'd20, 5'd0, 1'b1, 5'd20, 32'h1234,     1'b0, 1'b0, 16'h16, 1'b0, 1'b1, 32'h1234, 32'h0,  32'hAB};
        tbl[7]  = '{1'b1, 1'b0, 5'd3, 5'd20, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 16'h16, 1'b0, 1'b1, 32'h1234, 32'h0,  32'hAB};
        tbl[8]  = '{1'b1, 1'b0, 5'd4, 5'd10, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 16'h17, 1'b1, 1'b0, 32'h0,    32'h0,  32'hAB};
        tbl[9]  = '{1'b1, 1'b0, 5'd4, 5'd10, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 16'h18, 1'b0, 1'b1, 32'hAB,   32'hAB, 32'hAB};
        tbl[10] = '{1'b1, 1'b0, 5'd5, 5'd1,  5'd1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 16'h19, 1'b1, 1'b1, 32'hAB,   32'hAB, 32'hAB};
        tbl[11] = tbl[10];
        tbl[12] = tbl[10];

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 16'h0);
        model_reset();
        m_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].vld, tbl[i].ld, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].we,
                  tbl[i].a, tbl[i].wd, tbl[i].se, tbl[i].fl, tbl[i].ctrl);
            step();
            chk(i, "tbl_stall_fd", 32'(last_stall), 32'(tbl[i].e_stall));
            chk(i, "tbl_valid_e",  32'(valid_e0),   32'(tbl[i].e_valid));
            chk(i, "tbl_rd1_byp",  rd1_e0,          tbl[i].e_rd1_0);
            chk(i, "tbl_rd1_nobyp", rd1_e1,         tbl[i].e_rd1_1);
            chk(i, "tbl_a0",       a0_0,            tbl[i].e_a0);
        end

        // Randomised traffic; a stalled decode instruction is held as IF/ID would hold it.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] r [3];
            for (int k = 0; k < 3; k++)
                r[k] = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
            if (m_stall)
                drive(valid_d, is_load_d, instr_d[11:7], instr_d[19:15], instr_d[24:20],
                      $urandom_range(1) == 1, 5'($urandom_range(31)), $urandom,
                      $urandom_range(7) == 0, $urandom_range(9) == 0, ctrl_d);
            else
                drive($urandom_range(3) != 0, $urandom_range(2) == 0, r[0], r[1], r[2],
                      $urandom_range(1) == 1, ($urandom_range(3) == 0) ? 5'd10 : 5'($urandom_range(31)),
                      $urandom, $urandom_range(7) == 0, $urandom_range(9) == 0, 16'($urandom));
            step();
        end

        // Asynchronous reset between edges with a live EX slot and a pending write.
        drive(1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 5'd12, 32'h99, 1'b0, 1'b0, 16'h21);
        step();
        chk(0, "pre_rst_valid_e", 32'(valid_e0), 32'h1);
        drive(1'b1, 1'b0, 5'd1, 5'd12, 5'd3, 1'b1, 5'd12, 32'h77, 1'b0, 1'b0, 16'h22);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();
        drive(1'b1, 1'b0, 5'd1, 5'd12, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 16'h23);
        step();
        chk(0, "post_rst_x12", rd1_e0, 32'h0);
        chk(1, "post_rst_x12", rd1_e1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
